// File: rtl/ccd_pkg.sv
// Shared types and default constants for the CCD part-profile inspector.
package ccd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_PART = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_FINISH    = 2'd3
    } state_e;

    // Sample value the CCD reader reports when no part is in view.
    localparam int unsigned CCD_END_MARKER = 882;
    // Largest per-sample deviation from the learned profile still accepted.
    localparam int unsigned CCD_TOL        = 4;

endpackage

// File: rtl/profile_ram.sv
// Single-port profile buffer: synchronous write, one-cycle registered read.
module profile_ram #(
    parameter  int unsigned DATA_W = 12,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write on we_i; read data of the addressed entry appears the next cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/part_profile_inspector.sv
// Learns a part's CCD profile into a buffer, then inspects later parts
// against it sample by sample within a tolerance.
module part_profile_inspector
    import ccd_pkg::*;
#(
    parameter  int unsigned DATA_W     = 12,
    parameter  int unsigned DEPTH      = 1024,
    parameter  int unsigned END_MARKER = CCD_END_MARKER,
    parameter  int unsigned TOL        = CCD_TOL,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              ccd_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              len_err,
    output logic [ADDR_W:0]   mism_cnt,
    output logic [ADDR_W:0]   learned_len
);

    localparam logic [DATA_W-1:0] MARK_W  = DATA_W'(END_MARKER);
    localparam logic [DATA_W:0]   TOL_W   = (DATA_W+1)'(TOL);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   mism_q, mism_d;
    logic [ADDR_W:0]   learned_q, learned_d;
    logic              len_err_q, len_err_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              cmp_pend_q, cmp_pend_d;
    logic              cmp_force_q, cmp_force_d;
    logic [DATA_W-1:0] samp_q, samp_d;

    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              accept;
    logic              is_marker;
    logic              is_zero;
    logic [DATA_W:0]   lhs, rhs, diff;

    profile_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (idx_q[ADDR_W-1:0]),
        .wdata_i (sample_in),
        .rdata_o (ram_rdata)
    );

    assign is_marker = (sample_in == MARK_W);
    assign is_zero   = (sample_in == '0);

    // Unsigned distance with one guard bit so it cannot wrap.
    assign lhs  = {1'b0, samp_q};
    assign rhs  = {1'b0, ram_rdata};
    assign diff = (lhs >= rhs) ? (lhs - rhs) : (rhs - lhs);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            idx_q       <= '0;
            mism_q      <= '0;
            learned_q   <= '0;
            len_err_q   <= 1'b0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            cmp_pend_q  <= 1'b0;
            cmp_force_q <= 1'b0;
            samp_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            mism_q      <= mism_d;
            learned_q   <= learned_d;
            len_err_q   <= len_err_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            cmp_pend_q  <= cmp_pend_d;
            cmp_force_q <= cmp_force_d;
            samp_q      <= samp_d;
        end
    end

    // Next-state logic: sequencing, learn writes and the inspect compare pipeline.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        mism_d      = mism_q;
        learned_d   = learned_q;
        len_err_d   = len_err_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        cmp_pend_d  = 1'b0;
        cmp_force_d = 1'b0;
        samp_d      = samp_q;
        ram_we      = 1'b0;
        accept      = 1'b0;

        // Resolve the compare launched last cycle; RAM data is valid now.
        if (cmp_pend_q && (cmp_force_q || (diff > TOL_W)) && (mism_q != '1)) begin
            mism_d = mism_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mode_d    = mode;
                    idx_d     = '0;
                    mism_d    = '0;
                    len_err_d = 1'b0;
                    pass_d    = 1'b0;
                    if (mode && (learned_q == '0)) begin
                        len_err_d = 1'b1;
                        state_d   = ST_FINISH;
                    end else begin
                        state_d   = ST_WAIT_PART;
                    end
                end
            end
            ST_WAIT_PART: begin
                if (sample_valid && !is_marker) begin
                    accept  = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    if (is_marker) begin
                        state_d = ST_FINISH;
                        if (mode_q && (idx_q != learned_q)) begin
                            len_err_d = 1'b1;
                        end
                    end else if (!is_zero) begin
                        accept = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                // Last compare resolved above, so use the updated values.
                pass_d  = mode_q && (mism_d == '0) && !len_err_d;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (!mode_q && !len_err_q) begin
                    learned_d = idx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (!mode_q) begin
                if (idx_q == DEPTH_W) begin
                    len_err_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    ram_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                end
            end else begin
                // Read issued at idx now; compare happens next cycle.
                cmp_pend_d  = 1'b1;
                cmp_force_d = (idx_q >= learned_q);
                samp_d      = sample_in;
                if (idx_q >= learned_q) begin
                    len_err_d = 1'b1;
                end
                if (idx_q != '1) begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            ram_we     = 1'b0;
            done_d     = 1'b0;
            cmp_pend_d = 1'b0;
            learned_d  = learned_q;
            pass_d     = pass_q;
        end
    end

    assign ccd_en      = (state_q == ST_WAIT_PART) || (state_q == ST_CAPTURE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign pass        = pass_q;
    assign len_err     = len_err_q;
    assign mism_cnt    = mism_q;
    assign learned_len = learned_q;

endmodule

// File: tb/tb_part_profile_inspector.sv
// Self-checking bench: a default instance and a DEPTH=4 instance share stimulus
// and are each compared against a sample-list reference model.
module tb_part_profile_inspector;

    localparam int MARK = 882;
    localparam int TOLV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_in = '0;

    logic        ccd_en0, busy0, done0, pass0, len_err0;
    logic [10:0] mism0, llen0;
    logic        ccd_en1, busy1, done1, pass1, len_err1;
    logic [2:0]  mism1, llen1;

    int n_chk = 0;
    int n_err = 0;
    int done_seen [2] = '{0, 0};

    int m_mem  [2][1024];
    int m_llen [2] = '{0, 0};
    int e_mism [2];
    int e_lerr [2];
    int e_pass [2];
    int e_end  [2];

    always #5 clk = ~clk;

    part_profile_inspector dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .ccd_en(ccd_en0), .busy(busy0), .done(done0), .pass(pass0),
        .len_err(len_err0), .mism_cnt(mism0), .learned_len(llen0)
    );

    part_profile_inspector #(.DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .ccd_en(ccd_en1), .busy(busy1), .done(done1), .pass(pass1),
        .len_err(len_err1), .mism_cnt(mism1), .learned_len(llen1)
    );

    always @(negedge clk) begin
        if (done0 === 1'b1) done_seen[0]++;
        if (done1 === 1'b1) done_seen[1]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the valid-sample list as an operator would describe it.
    task automatic model(input int d, input bit m, input int s[$], input int n);
        int  cnt = 0;
        int  mc  = 0;
        bit  le  = 0;
        bit  ended = 0;
        bit  started = 0;
        int  dep = (d == 0) ? 1024 : 4;
        int  cap = (d == 0) ? 2047 : 7;
        int  v;
        if (m && m_llen[d] == 0) begin
            le = 1;
            ended = 1;
        end
        for (int i = 0; i < n && !ended; i++) begin
            v = s[i];
            if (!started) begin
                if (v == MARK) continue;
                started = 1;
            end else begin
                if (v == MARK) begin
                    ended = 1;
                    if (m && cnt != m_llen[d]) le = 1;
                    break;
                end
                if (v == 0) continue;
            end
            if (!m) begin
                if (cnt == dep) begin
                    le = 1;
                    ended = 1;
                    break;
                end
                m_mem[d][cnt] = v;
                cnt++;
            end else begin
                if (cnt >= m_llen[d]) begin
                    mc++;
                    le = 1;
                end else if ((v > m_mem[d][cnt] ? v - m_mem[d][cnt] : m_mem[d][cnt] - v) > TOLV) begin
                    mc++;
                end
                cnt++;
            end
        end
        if (ended && !m && !le) m_llen[d] = cnt;
        e_mism[d] = (mc > cap) ? cap : mc;
        e_lerr[d] = le;
        e_pass[d] = (m && mc == 0 && !le) ? 1 : 0;
        e_end[d]  = ended;
    endtask

    task automatic check_dut(input int d, input string tag);
        if (d == 0) begin
            chk({tag, "/mism0"}, 32'(mism0), e_mism[0]);
            chk({tag, "/lerr0"}, 32'(len_err0), e_lerr[0]);
            chk({tag, "/pass0"}, 32'(pass0), e_pass[0]);
            chk({tag, "/busy0"}, 32'(busy0), 0);
        end else begin
            chk({tag, "/mism1"}, 32'(mism1), e_mism[1]);
            chk({tag, "/lerr1"}, 32'(len_err1), e_lerr[1]);
            chk({tag, "/pass1"}, 32'(pass1), e_pass[1]);
            chk({tag, "/busy1"}, 32'(busy1), 0);
        end
    endtask

    task automatic run_op(input string tag, input bit m, input int s[$], input int abort_at, input int gap);
        int n;
        int base [2];
        int expd [2];
        bit imm  [2];
        bit aborted = 0;
        n = (abort_at < 0) ? s.size() : abort_at;
        for (int d = 0; d < 2; d++) begin
            base[d] = done_seen[d];
            imm[d]  = m && (m_llen[d] == 0);
            model(d, m, s, n);
        end
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        chk({tag, "/busy0_start"}, 32'(busy0), 1);
        chk({tag, "/ccden0_start"}, 32'(ccd_en0), imm[0] ? 0 : 1);
        chk({tag, "/ccden1_start"}, 32'(ccd_en1), imm[1] ? 0 : 1);
        for (int i = 0; i < s.size(); i++) begin
            if (i == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                aborted = 1;
                chk({tag, "/busy0_abort"}, 32'(busy0), 0);
                chk({tag, "/busy1_abort"}, 32'(busy1), 0);
                break;
            end
            repeat ($urandom_range(0, gap)) begin
                sample_in = 12'($urandom);
                @(posedge clk); #1;
            end
            sample_valid = 1'b1;
            sample_in    = 12'(s[i]);
            @(posedge clk); #1;
            sample_valid = 1'b0;
        end
        for (int d = 0; d < 2; d++)
            expd[d] = base[d] + ((!aborted || e_end[d]) ? 1 : 0);
        for (int k = 0; k < 40; k++) begin
            if (done_seen[0] >= expd[0] && done_seen[1] >= expd[1]) break;
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk({tag, "/done0"}, 32'(done_seen[0]), expd[0]);
        chk({tag, "/done1"}, 32'(done_seen[1]), expd[1]);
        chk({tag, "/llen0"}, 32'(llen0), m_llen[0]);
        chk({tag, "/llen1"}, 32'(llen1), m_llen[1]);
        for (int d = 0; d < 2; d++)
            if (!aborted || e_end[d]) check_dut(d, tag);
    endtask

    initial begin
        int s[$];
        int len;
        int v;
        bit m;

        #2;
        chk("rst/ccden0", 32'(ccd_en0), 0);
        chk("rst/busy0", 32'(busy0), 0);
        chk("rst/done0", 32'(done0), 0);
        chk("rst/pass0", 32'(pass0), 0);
        chk("rst/lerr0", 32'(len_err0), 0);
        chk("rst/mism0", 32'(mism0), 0);
        chk("rst/llen0", 32'(llen0), 0);
        chk("rst/busy1", 32'(busy1), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("learn3", 0, '{MARK, MARK, MARK, 100, 0, 200, 300, MARK}, -1, 0);
        chk("learn3/llen_is_3", 32'(llen0), 3);
        run_op("insp_ok", 1, '{103, 198, 300, MARK}, -1, 0);
        run_op("insp_tol_edge", 1, '{104, 196, 300, MARK}, -1, 0);
        run_op("insp_two_off", 1, '{105, 200, 295, MARK}, -1, 1);
        run_op("insp_one_off", 1, '{100, 210, 300, MARK}, -1, 0);
        chk("insp_one_off/mism_is_1", 32'(mism0), 1);
        run_op("insp_short", 1, '{100, 200, MARK}, -1, 0);
        run_op("insp_long", 1, '{100, 200, 300, 400, MARK}, -1, 2);
        run_op("learn_ovf", 0, '{11, 22, 33, 44, 55, 66, MARK}, -1, 0);
        chk("learn_ovf/lerr1", 32'(len_err1), 1);
        run_op("abort", 0, '{MARK, 500, 600, 700, MARK}, 3, 0);
        run_op("insp_after_abort", 1, '{500, 600, 33, 44, 55, 66, MARK}, -1, 0);

        for (int t = 0; t < 30; t++) begin
            s.delete();
            m = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) s.push_back(MARK);
            if (!m) begin
                len = int'($urandom_range(1, 7));
            end else begin
                len = m_llen[0] + int'($urandom_range(0, 2)) - 1;
                if (len < 1) len = 1;
            end
            for (int j = 0; j < len; j++) begin
                if (j > 0 && $urandom_range(0, 4) == 0) s.push_back(0);
                if (m && j < m_llen[0])
                    v = m_mem[0][j] + int'($urandom_range(0, 10)) - 5;
                else
                    v = int'($urandom_range(16, 4000));
                if (v == MARK) v++;
                s.push_back(v);
            end
            s.push_back(MARK);
            run_op("rand", m, s, -1, $urandom_range(0, 1) ? 0 : 2);
        end

        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 12'd700;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst/ccden0", 32'(ccd_en0), 0);
        chk("midrst/busy0", 32'(busy0), 0);
        chk("midrst/done0", 32'(done0), 0);
        chk("midrst/pass0", 32'(pass0), 0);
        chk("midrst/lerr0", 32'(len_err0), 0);
        chk("midrst/mism0", 32'(mism0), 0);
        chk("midrst/llen0", 32'(llen0), 0);
        chk("midrst/llen1", 32'(llen1), 0);
        chk("midrst/busy1", 32'(busy1), 0);
        m_llen[0] = 0;
        m_llen[1] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("insp_empty", 1, '{100, MARK}, -1, 0);
        chk("insp_empty/lerr0", 32'(len_err0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
